// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// Contents:
//   state_t        FSM states of the divider (IDLE, CALC, DONE)
//   clog2()        ceiling log2, used to size the iteration counter
//   cnt_width()    bits needed to count WIDTH iterations (clog2(WIDTH+1))
//   DBZ_QUOT_FILL  fill bit of the quotient reported on divide-by-zero
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Never returns less than 1 so that a degenerate width still yields a legal vector.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

  // The counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return clog2(width + 1);
  endfunction

  // Divide-by-zero reports a quotient of all ones, whatever the width.
  localparam logic DBZ_QUOT_FILL = 1'b1;

endpackage

// File: rtl/seq_div_sign.sv
// Sign handling around the unsigned restoring divider core (purely combinational).
// Ports:
//   sign          in   1      1 = operands are two's complement
//   dividend      in   WIDTH  raw dividend from the requester
//   divisor       in   WIDTH  raw divisor from the requester
//   abs_dividend  out  WIDTH  magnitude of dividend
//   abs_divisor   out  WIDTH  magnitude of divisor
//   neg_quot      out  1      quotient must be negated (operand signs differ)
//   neg_rem       out  1      remainder must be negated (dividend negative)
//   raw_quot      in   WIDTH  unsigned quotient from the core
//   raw_rem       in   WIDTH  unsigned remainder from the core
//   neg_quot_sel  in   1      negation flag captured at accept time
//   neg_rem_sel   in   1      negation flag captured at accept time
//   signed_quot   out  WIDTH  final quotient
//   signed_rem    out  WIDTH  final remainder
module seq_div_sign #(
  parameter int WIDTH = 16
) (
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] abs_dividend,
  output logic [WIDTH-1:0] abs_divisor,
  output logic             neg_quot,
  output logic             neg_rem,
  input  logic [WIDTH-1:0] raw_quot,
  input  logic [WIDTH-1:0] raw_rem,
  input  logic             neg_quot_sel,
  input  logic             neg_rem_sel,
  output logic [WIDTH-1:0] signed_quot,
  output logic [WIDTH-1:0] signed_rem
);

  logic dividend_neg;
  logic divisor_neg;

  // The most negative value maps onto itself, which the unsigned core
  // reads correctly as 2^(WIDTH-1).
  always_comb begin
    dividend_neg = sign & dividend[WIDTH-1];
    divisor_neg  = sign & divisor[WIDTH-1];
    abs_dividend = dividend_neg ? (~dividend + 1'b1) : dividend;
    abs_divisor  = divisor_neg  ? (~divisor + 1'b1)  : divisor;
    neg_quot     = dividend_neg ^ divisor_neg;
    neg_rem      = dividend_neg;
  end

  // Truncating division: remainder follows the dividend's sign.
  always_comb begin
    signed_quot = neg_quot_sel ? (~raw_quot + 1'b1) : raw_quot;
    signed_rem  = neg_rem_sel  ? (~raw_rem + 1'b1)  : raw_rem;
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// One quotient bit per cycle, MSB first; WIDTH cycles of CALC per operation.
// Optional feature macro: SEQ_DIV_OVF_EN -- when defined, signed
//   -2^(WIDTH-1) / -1 is caught on accept and reported through error.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      request, accepted in IDLE or DONE
//   sign       in   1      1 = signed operands, 0 = unsigned
//   dividend   in   WIDTH  numerator, sampled on accept
//   divisor    in   WIDTH  denominator, sampled on accept
//   busy       out  1      high while computing
//   done       out  1      high for the cycle results become valid
//   quotient   out  WIDTH  result, held until next accept
//   remainder  out  WIDTH  result, held until next accept
//   error      out  1      divide-by-zero or overflow
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]    ITERS    = CW'(WIDTH);
  localparam logic [CW-1:0]    LAST     = CW'(1);
  localparam logic [WIDTH-1:0] DBZ_QUOT = {WIDTH{DBZ_QUOT_FILL}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic             in_neg_quot;
  logic             in_neg_rem;
  logic [WIDTH-1:0] signed_quot;
  logic [WIDTH-1:0] signed_rem;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             accept;
  logic             ovf_hit;

  seq_div_sign #(.WIDTH(WIDTH)) u_sign (
    .sign         (sign),
    .dividend     (dividend),
    .divisor      (divisor),
    .abs_dividend (abs_dividend),
    .abs_divisor  (abs_divisor),
    .neg_quot     (in_neg_quot),
    .neg_rem      (in_neg_rem),
    .raw_quot     (step_quo),
    .raw_rem      (step_rem[WIDTH-1:0]),
    .neg_quot_sel (neg_quot_q),
    .neg_rem_sel  (neg_rem_q),
    .signed_quot  (signed_quot),
    .signed_rem   (signed_rem)
  );

`ifdef SEQ_DIV_OVF_EN
  assign ovf_hit = sign && (dividend == MIN_NEG) && (divisor == {WIDTH{1'b1}});
`else
  assign ovf_hit = 1'b0;
`endif

  // One restoring step. The partial remainder is always below the divisor,
  // so after shifting in the next dividend bit it fits in WIDTH+1 bits and
  // bit WIDTH of the trial difference acts as the borrow.
  always_comb begin
    shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      step_rem = trial;
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = shifted;
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic. The quotient register starts out holding the dividend
  // magnitude and is shifted left as quotient bits come in from the right.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;
    accept      = start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE: ;
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAST) begin
          state_d     = DONE;
          quotient_d  = signed_quot;
          remainder_d = signed_rem;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Exceptional operands skip CALC and report straight away.
    if (accept) begin
      error_d    = 1'b0;
      neg_quot_d = in_neg_quot;
      neg_rem_d  = in_neg_rem;
      rem_d      = '0;
      quo_d      = abs_dividend;
      dvs_d      = abs_divisor;
      cnt_d      = ITERS;
      if (divisor == '0) begin
        state_d     = DONE;
        error_d     = 1'b1;
        quotient_d  = DBZ_QUOT;
        remainder_d = dividend;
      end else if (ovf_hit) begin
        state_d     = DONE;
        error_d     = 1'b1;
        quotient_d  = MIN_NEG;
        remainder_d = '0;
      end else begin
        state_d = CALC;
      end
    end
  end

  // State and result registers; reset also aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign error     = error_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=16).
// A timeline model predicts busy/done per cycle and the arithmetic result of
// each accepted operation; literal expectations pin individual results.
// Honours SEQ_DIV_OVF_EN for the overflow case.
module tb_seq_div;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sign;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         error;

  seq_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Model state
  bit           model_ready = 0;
  bit           op_active   = 0;
  int           acc_cyc     = 0;
  int           done_cyc    = 0;
  logic [W-1:0] pend_q, pend_r;
  logic         pend_e;
  logic [W-1:0] exp_q, exp_r;
  logic         exp_e;
  bit           res_valid   = 0;
  bit           exp_busy, exp_done;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Result of one operation from the arithmetic rules alone.
  function automatic void modelOp(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic e, output int lat);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; e = 1'b1; lat = 1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      q = 16'h8000; r = '0;
`ifdef SEQ_DIV_OVF_EN
      e = 1'b1; lat = 1;
`else
      e = 1'b0; lat = W + 1;
`endif
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
      e = 1'b0; lat = W + 1;
    end
  endfunction

  task automatic modelReset();
    op_active = 0;
    res_valid = 1;
    exp_q = '0; exp_r = '0; exp_e = 1'b0;
  endtask

  task automatic modelAccept();
    int lat;
    modelOp(sign, dividend, divisor, pend_q, pend_r, pend_e, lat);
    op_active = 1;
    acc_cyc   = cyc;
    done_cyc  = cyc + lat - 1;
    res_valid = 0;
  endtask

  // Advance one edge and tell the model what the DUT saw at it.
  task automatic tick();
    bit was_busy;
    was_busy = op_active && (cyc < done_cyc);
    @(posedge clk);
    #1;
    if (rst) modelReset();
    else if (start && !was_busy) modelAccept();
  endtask

  task automatic applyStimulus(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    sign = s; dividend = a; divisor = b; start = 1'b1;
    tick();
    start = 1'b0;
    dividend = $urandom_range(0, 65535);
    divisor  = $urandom_range(0, 65535);
  endtask

  task automatic waitDone(input string name, input int lat, input logic [W-1:0] q,
                          input logic [W-1:0] r, input logic e);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s_timeout: got no done, expected done within 40 cycles", name);
    end else begin
      checkOutput({name, "_latency"}, cyc - acc_cyc + 1, lat);
      checkOutput({name, "_quotient"}, quotient, q);
      checkOutput({name, "_remainder"}, remainder, r);
      checkOutput({name, "_error"}, error, e);
    end
  endtask

  // Per-cycle comparison against the model timeline.
  always @(negedge clk) begin
    if (model_ready && !rst) begin
      exp_busy = op_active && (cyc < done_cyc);
      exp_done = op_active && (cyc == done_cyc);
      checkOutput("busy", busy, exp_busy);
      checkOutput("done", done, exp_done);
      if (exp_done) begin
        exp_q = pend_q; exp_r = pend_r; exp_e = pend_e;
        res_valid = 1;
        op_active = 0;
      end
      if (res_valid) begin
        checkOutput("model_quotient", quotient, exp_q);
        checkOutput("model_remainder", remainder, exp_r);
        checkOutput("model_error", error, exp_e);
      end else begin
        checkOutput("error_cleared", error, 1'b0);
      end
    end
  end

  typedef struct {
    bit           s;
    logic [W-1:0] a, b, q, r;
    logic         e;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [W-1:0] mq, mr;
    logic         me;
    int           ml;

    rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    rst = 1'b0;
    model_ready = 1;

    // Pin the model with hand-computed results.
    modelOp(1'b1, 16'hFFF9, 16'd2, mq, mr, me, ml);
    checkOutput("pin_neg7_div2_q", mq, 16'hFFFD);
    checkOutput("pin_neg7_div2_r", mr, 16'hFFFF);
    modelOp(1'b0, 16'd1000, 16'd7, mq, mr, me, ml);
    checkOutput("pin_1000_div7_q", mq, 16'd142);
    checkOutput("pin_1000_div7_r", mr, 16'd6);

    @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_quotient", quotient, 16'd0);
    checkOutput("reset_remainder", remainder, 16'd0);
    checkOutput("reset_error", error, 1'b0);

    // 100/2 with an ignored start pulse while busy
    applyStimulus(1'b0, 16'd100, 16'd2);
    tick(); tick(); tick();
    applyStimulus(1'b0, 16'd999, 16'd7);
    waitDone("t1_100_div_2", 17, 16'd50, 16'd0, 1'b0);

    // back-to-back accept in DONE
    applyStimulus(1'b0, 16'd8, 16'd4);
    waitDone("t2_8_div_4", 17, 16'd2, 16'd0, 1'b0);

    applyStimulus(1'b1, 16'd10, 16'd0);
    waitDone("t3_div_zero", 1, 16'hFFFF, 16'd10, 1'b1);

    applyStimulus(1'b1, 16'hFFF9, 16'd2);
    waitDone("t4_neg7_div_2", 17, 16'hFFFD, 16'hFFFF, 1'b0);

    applyStimulus(1'b1, 16'h8000, 16'hFFFF);
`ifdef SEQ_DIV_OVF_EN
    waitDone("t5_overflow", 1, 16'h8000, 16'd0, 1'b1);
`else
    waitDone("t5_overflow", 17, 16'h8000, 16'd0, 1'b0);
`endif

    vecs.push_back('{1'b0, 16'hFFFF, 16'd3,     16'd21845, 16'd0,     1'b0, 17});
    vecs.push_back('{1'b0, 16'd1000, 16'd7,     16'd142,   16'd6,     1'b0, 17});
    vecs.push_back('{1'b1, 16'd7,    16'hFFFE,  16'hFFFD,  16'd1,     1'b0, 17});
    vecs.push_back('{1'b0, 16'h8000, 16'hFFFF,  16'd0,     16'h8000,  1'b0, 17});
    vecs.push_back('{1'b0, 16'd5,    16'd0,     16'hFFFF,  16'd5,     1'b1, 1});
    vecs.push_back('{1'b1, 16'hFF9C, 16'hFFF9,  16'd14,    16'hFFFE,  1'b0, 17});
    vecs.push_back('{1'b0, 16'd3,    16'd9,     16'd0,     16'd3,     1'b0, 17});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].b);
      waitDone($sformatf("vec%0d", i), vecs[i].lat, vecs[i].q, vecs[i].r, vecs[i].e);
    end

    // Abort mid-CALC with reset
    applyStimulus(1'b0, 16'hFFFF, 16'd3);
    tick(); tick(); tick();
    applyStimulus(1'b0, 16'd5, 16'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    checkOutput("t6_abort_busy", busy, 1'b0);
    checkOutput("t6_abort_done", done, 1'b0);
    checkOutput("t6_abort_quotient", quotient, 16'd0);
    checkOutput("t6_abort_remainder", remainder, 16'd0);
    checkOutput("t6_abort_error", error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
